// File: rtl/prog_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prog_load_ctrl
// Description : Boot and run sequencer for the CPU's unified memory write
//               port. Streams a program image into consecutive addresses,
//               holds the CPU in reset while loading, then flushes, releases
//               and runs the CPU for a cycle budget or until halted.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_load_ctrl #(
    parameter int ADRS_W       = 11,
    parameter int DATA_W       = 32,
    parameter int BASE_ADRS    = 1,
    parameter int MAX_ADRS     = 2047,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              run_req,
    input  logic [15:0]       run_cycles,
    input  logic              halt_req,
    output logic              mem_w_enable,
    output logic [ADRS_W-1:0] mem_w_adrs,
    output logic [DATA_W-1:0] mem_w_data,
    output logic              cpu_en,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              run_done,
    output logic [ADRS_W:0]   load_count,
    output logic              ovf_err
);

    // Index arithmetic is carried one bit wider than load_count so that
    // BASE_ADRS + load_count can never wrap before the range compare.
    localparam int IDX_W = ADRS_W + 2;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    localparam logic [FC_W-1:0]  c_flush_last = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [IDX_W-1:0] c_base       = IDX_W'(BASE_ADRS);
    localparam logic [IDX_W-1:0] c_max        = IDX_W'(MAX_ADRS);
    localparam logic [ADRS_W:0]  c_one        = (ADRS_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t            r_state;
    logic [FC_W-1:0]   r_flush_cnt;
    logic [15:0]       r_run_len;
    logic [15:0]       r_run_cnt;

    logic              w_xfer;
    logic [ADRS_W:0]   w_idx;
    logic [IDX_W-1:0]  w_wr_adrs;
    logic              w_in_range;
    logic              w_run_end;

    // Beat handshake, write slot (a new image starts at index 0) and run end.
    always_comb begin
        w_xfer     = ld_valid && ld_ready;
        w_idx      = (r_state == S_IDLE) ? '0 : load_count;
        w_wr_adrs  = c_base + {1'b0, w_idx};
        w_in_range = (w_wr_adrs <= c_max);
        w_run_end  = halt_req ||
                     ((r_run_len != 16'd0) && (r_run_cnt == (r_run_len - 16'd1)));
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_flush_cnt  <= '0;
            r_run_len    <= '0;
            r_run_cnt    <= '0;
            ld_ready     <= 1'b0;
            mem_w_enable <= 1'b0;
            mem_w_adrs   <= ADRS_W'(BASE_ADRS);
            mem_w_data   <= '0;
            cpu_en       <= 1'b0;
            cpu_rst_n    <= 1'b0;
            busy         <= 1'b0;
            run_done     <= 1'b0;
            load_count   <= '0;
            ovf_err      <= 1'b0;
        end else begin
            mem_w_enable <= 1'b0;
            run_done     <= 1'b0;

            // Accepted beats are written one cycle later; out-of-range beats
            // are drained without a write and flag the overflow.
            if (w_xfer) begin
                if (w_in_range) begin
                    mem_w_enable <= 1'b1;
                    mem_w_adrs   <= w_wr_adrs[ADRS_W-1:0];
                    mem_w_data   <= ld_data;
                    load_count   <= w_idx + c_one;
                    if (r_state == S_IDLE) begin
                        ovf_err <= 1'b0;
                    end
                end else begin
                    load_count <= w_idx;
                    ovf_err    <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    ld_ready <= 1'b1;
                    if (w_xfer) begin
                        cpu_rst_n <= 1'b0;
                        cpu_en    <= 1'b0;
                        if (ld_last) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_state <= S_LOAD;
                            busy    <= 1'b1;
                        end
                    end else if (run_req) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= '0;
                        r_run_len   <= run_cycles;
                        cpu_rst_n   <= 1'b0;
                        cpu_en      <= 1'b0;
                        busy        <= 1'b1;
                        ld_ready    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_xfer && ld_last) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_FLUSH: begin
                    if (r_flush_cnt == c_flush_last) begin
                        r_state   <= S_RUN;
                        r_run_cnt <= '0;
                        cpu_rst_n <= 1'b1;
                        cpu_en    <= 1'b1;
                    end else begin
                        r_flush_cnt <= r_flush_cnt + FC_W'(1);
                    end
                end
                S_RUN: begin
                    if (w_run_end) begin
                        r_state <= S_HALT;
                        cpu_en  <= 1'b0;
                    end else begin
                        // Free-running in unbounded mode; a wrap is harmless.
                        r_run_cnt <= r_run_cnt + 16'd1;
                    end
                end
                S_HALT: begin
                    r_state  <= S_IDLE;
                    run_done <= 1'b1;
                    busy     <= 1'b0;
                    ld_ready <= 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    busy     <= 1'b0;
                    ld_ready <= 1'b0;
                    cpu_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_load_ctrl
// Description : Self-checking bench for prog_load_ctrl. Two instances share
//               one stimulus: base address 1 and base address 2045 (small
//               space, overflows quickly). Directed table, directed sequences
//               and randomized loads/runs checked against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_load_ctrl;

    localparam int MAXA = 2047;
    localparam int FC   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid, ld_last, run_req, halt_req;
    logic [31:0] ld_data;
    logic [15:0] run_cycles;

    logic        a_ready, a_wen, a_en, a_rstn, a_busy, a_done, a_ovf;
    logic [10:0] a_adrs;
    logic [31:0] a_data;
    logic [11:0] a_lc;
    logic        b_ready, b_wen, b_en, b_rstn, b_busy, b_done, b_ovf;
    logic [10:0] b_adrs;
    logic [31:0] b_data;
    logic [11:0] b_lc;

    int n_checks = 0;
    int n_err    = 0;

    // Transaction-level model state
    int   m_lc  [2];
    logic m_ovf [2];
    logic m_rstn;
    logic m_ready;

    always #5 clk = ~clk;

    prog_load_ctrl #(.BASE_ADRS(1)) u_a (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(a_ready),
        .ld_data(ld_data), .ld_last(ld_last), .run_req(run_req),
        .run_cycles(run_cycles), .halt_req(halt_req), .mem_w_enable(a_wen),
        .mem_w_adrs(a_adrs), .mem_w_data(a_data), .cpu_en(a_en),
        .cpu_rst_n(a_rstn), .busy(a_busy), .run_done(a_done),
        .load_count(a_lc), .ovf_err(a_ovf)
    );

    prog_load_ctrl #(.BASE_ADRS(2045)) u_b (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_ready(b_ready),
        .ld_data(ld_data), .ld_last(ld_last), .run_req(run_req),
        .run_cycles(run_cycles), .halt_req(halt_req), .mem_w_enable(b_wen),
        .mem_w_adrs(b_adrs), .mem_w_data(b_data), .cpu_en(b_en),
        .cpu_rst_n(b_rstn), .busy(b_busy), .run_done(b_done),
        .load_count(b_lc), .ovf_err(b_ovf)
    );

    typedef struct {
        logic        wen;
        logic        ad;      // compare adrs/data even without a write
        logic [10:0] adrs;
        logic [31:0] data;
        logic        ready, busy;
        logic [11:0] lc;
        logic        ovf, en, rstn, done;
    } obs_t;

    typedef struct {
        logic        v, last;
        logic [31:0] data;
        logic        rreq;
        logic        e_wen;
        logic [10:0] e_adrs;
        logic [31:0] e_data;
        logic        e_busy;
        logic [11:0] e_lc;
        logic        e_rstn;
    } vec_t;

    function automatic int base_of(int d);
        return (d == 0) ? 1 : 2045;
    endfunction

    function automatic obs_t get_act(int d);
        obs_t a;
        if (d == 0) begin
            a.wen = a_wen; a.adrs = a_adrs; a.data = a_data; a.ready = a_ready;
            a.busy = a_busy; a.lc = a_lc; a.ovf = a_ovf; a.en = a_en;
            a.rstn = a_rstn; a.done = a_done;
        end else begin
            a.wen = b_wen; a.adrs = b_adrs; a.data = b_data; a.ready = b_ready;
            a.busy = b_busy; a.lc = b_lc; a.ovf = b_ovf; a.en = b_en;
            a.rstn = b_rstn; a.done = b_done;
        end
        a.ad = 1'b0;
        return a;
    endfunction

    function automatic obs_t e_idle(int d);
        obs_t e;
        e.wen = 1'b0; e.ad = 1'b0; e.adrs = '0; e.data = '0;
        e.ready = m_ready; e.busy = 1'b0; e.lc = 12'(m_lc[d]);
        e.ovf = m_ovf[d]; e.en = 1'b0; e.rstn = m_rstn; e.done = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input int d, input obs_t e);
        obs_t a;
        bit   bad;
        a = get_act(d);
        n_checks++;
        bad = (a.wen !== e.wen) || (a.ready !== e.ready) || (a.busy !== e.busy) ||
              (a.lc !== e.lc) || (a.ovf !== e.ovf) || (a.en !== e.en) ||
              (a.rstn !== e.rstn) || (a.done !== e.done);
        if (e.wen || e.ad)
            bad = bad || (a.adrs !== e.adrs) || (a.data !== e.data);
        if (bad) begin
            n_err++;
            $display("FAIL %s dut%0d t=%0t got wen=%0b adrs=%0d data=%h ready=%0b busy=%0b lc=%0d ovf=%0b en=%0b rstn=%0b done=%0b | want wen=%0b adrs=%0d data=%h ready=%0b busy=%0b lc=%0d ovf=%0b en=%0b rstn=%0b done=%0b",
                     tag, d, $time, a.wen, a.adrs, a.data, a.ready, a.busy, a.lc, a.ovf,
                     a.en, a.rstn, a.done, e.wen, e.adrs, e.data, e.ready, e.busy, e.lc,
                     e.ovf, e.en, e.rstn, e.done);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic lst,
                         input logic [31:0] dat, input logic rr,
                         input logic [15:0] rc, input logic h);
        reset = rst; ld_valid = v; ld_last = lst; ld_data = dat;
        run_req = rr; run_cycles = rc; halt_req = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset_row(input string tag);
        obs_t e;
        drive(1'b1, 1'b1, 1'($urandom_range(1, 0)), $urandom, 1'b1, 16'd5, 1'b1);
        step();
        m_lc[0] = 0; m_lc[1] = 0; m_ovf[0] = 1'b0; m_ovf[1] = 1'b0;
        m_rstn = 1'b0; m_ready = 1'b0;
        for (int d = 0; d < 2; d++) begin
            e = e_idle(d);
            e.ad = 1'b1; e.adrs = 11'(base_of(d)); e.data = '0;
            chk(tag, d, e);
        end
    endtask

    task automatic idle_row(input string tag);
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        step();
        m_ready = 1'b1;
        for (int d = 0; d < 2; d++) chk(tag, d, e_idle(d));
    endtask

    // Image of n words; optional random gaps and ignored run_req; optional
    // reset at row abort_at.
    task automatic do_load(input logic [31:0] w[$], input bit gaps, input bit rnd_run,
                           input int abort_at);
        int   i, r, cap;
        logic v;
        obs_t e;
        i = 0; r = 0;
        while (i < w.size()) begin
            if (r == abort_at) begin
                do_reset_row("load_reset");
                idle_row("load_reset_idle");
                return;
            end
            v = (r == 0) || !gaps || ($urandom_range(1, 0) == 1);
            if (v)
                drive(1'b0, 1'b1, i == w.size() - 1, w[i],
                      rnd_run ? 1'($urandom_range(1, 0)) : 1'b0, 16'($urandom), 1'b0);
            else
                drive(1'b0, 1'b0, 1'($urandom_range(1, 0)), $urandom,
                      rnd_run ? 1'($urandom_range(1, 0)) : 1'b0, 16'($urandom), 1'b0);
            step();
            if (v && i == 0) m_rstn = 1'b0;
            for (int d = 0; d < 2; d++) begin
                e = e_idle(d);
                if (v) begin
                    if (i == 0) begin m_lc[d] = 0; m_ovf[d] = 1'b0; end
                    cap = MAXA - base_of(d) + 1;
                    if (m_lc[d] < cap) begin
                        e.wen = 1'b1; e.adrs = 11'(base_of(d) + m_lc[d]); e.data = w[i];
                        m_lc[d]++;
                    end else begin
                        m_ovf[d] = 1'b1;
                    end
                end
                e.lc = 12'(m_lc[d]); e.ovf = m_ovf[d]; e.rstn = m_rstn; e.ready = 1'b1;
                e.busy = !(v && i == w.size() - 1);
                chk(v ? "load_beat" : "load_gap", d, e);
            end
            if (v) i++;
            r++;
        end
        idle_row("load_end");
    endtask

    // Row 0 carries run_req. CPU reset low for rows 0..FC-1, cpu_en high for
    // rows FC..end-1, HALT observed at row end, run_done at row end+1.
    task automatic do_run(input int rc, input int halt_k, input int abort_at);
        int   endr, hrow;
        obs_t e;
        endr = (rc != 0) ? FC + rc : 32'h3fff_ffff;
        hrow = (halt_k >= 0) ? FC + 1 + halt_k : -1;
        if (hrow >= 0 && hrow < endr) endr = hrow;
        for (int r = 0; r <= endr + 2; r++) begin
            if (r == abort_at) begin
                do_reset_row("run_reset");
                idle_row("run_reset_idle");
                return;
            end
            if (r == 0)
                drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 16'(rc), 1'b0);
            else if (r <= endr)
                drive(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), $urandom,
                      1'($urandom_range(1, 0)), 16'($urandom), r == hrow);
            else
                drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
            step();
            for (int d = 0; d < 2; d++) begin
                e = e_idle(d);
                e.busy  = (r <= endr);
                e.ready = (r > endr);
                e.en    = (r >= FC) && (r < endr);
                e.rstn  = (r >= FC);
                e.done  = (r == endr + 1);
                chk("run", d, e);
            end
        end
        m_rstn = 1'b1; m_ready = 1'b1;
    endtask

    function automatic vec_t mk(logic v, logic lst, logic [31:0] dat, logic rr,
                                logic ew, logic [10:0] ea, logic [31:0] ed,
                                logic eb, logic [11:0] el, logic er);
        vec_t t;
        t.v = v; t.last = lst; t.data = dat; t.rreq = rr; t.e_wen = ew;
        t.e_adrs = ea; t.e_data = ed; t.e_busy = eb; t.e_lc = el; t.e_rstn = er;
        return t;
    endfunction

    initial begin
        vec_t        tbl [15];
        obs_t        e;
        logic [31:0] q[$];
        int          rc, hk, n;

        // Back-to-back image, gapped image, then beat+run_req priority.
        tbl[0]  = mk(1, 0, 32'hE000_300A, 0, 1, 11'd1, 32'hE000_300A, 1, 12'd1, 0);
        tbl[1]  = mk(1, 0, 32'hE008_C00B, 0, 1, 11'd2, 32'hE008_C00B, 1, 12'd2, 0);
        tbl[2]  = mk(1, 1, 32'h8080_3005, 0, 1, 11'd3, 32'h8080_3005, 0, 12'd3, 0);
        tbl[3]  = mk(0, 0, 32'h0,         0, 0, 11'd0, 32'h0,         0, 12'd3, 0);
        tbl[4]  = mk(1, 0, 32'h1111_1111, 0, 1, 11'd1, 32'h1111_1111, 1, 12'd1, 0);
        tbl[5]  = mk(0, 1, 32'hDEAD_0000, 0, 0, 11'd0, 32'h0,         1, 12'd1, 0);
        tbl[6]  = mk(0, 0, 32'hDEAD_0001, 0, 0, 11'd0, 32'h0,         1, 12'd1, 0);
        tbl[7]  = mk(1, 0, 32'h2222_2222, 0, 1, 11'd2, 32'h2222_2222, 1, 12'd2, 0);
        tbl[8]  = mk(0, 0, 32'hDEAD_0002, 0, 0, 11'd0, 32'h0,         1, 12'd2, 0);
        tbl[9]  = mk(1, 1, 32'h3333_3333, 0, 1, 11'd3, 32'h3333_3333, 0, 12'd3, 0);
        tbl[10] = mk(0, 0, 32'h0,         0, 0, 11'd0, 32'h0,         0, 12'd3, 0);
        tbl[11] = mk(1, 0, 32'hAAAA_0001, 1, 1, 11'd1, 32'hAAAA_0001, 1, 12'd1, 0);
        tbl[12] = mk(1, 1, 32'hAAAA_0002, 1, 1, 11'd2, 32'hAAAA_0002, 0, 12'd2, 0);
        tbl[13] = mk(0, 0, 32'h0,         0, 0, 11'd0, 32'h0,         0, 12'd2, 0);
        tbl[14] = mk(0, 0, 32'h0,         0, 0, 11'd0, 32'h0,         0, 12'd2, 0);

        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 16'd0, 1'b0);
        do_reset_row("reset_state");
        do_reset_row("reset_state2");
        idle_row("post_reset_idle");

        for (int k = 0; k < 15; k++) begin
            drive(1'b0, tbl[k].v, tbl[k].last, tbl[k].data, tbl[k].rreq, 16'd7, 1'b0);
            step();
            e.wen = tbl[k].e_wen; e.ad = 1'b0; e.adrs = tbl[k].e_adrs;
            e.data = tbl[k].e_data; e.ready = 1'b1; e.busy = tbl[k].e_busy;
            e.lc = tbl[k].e_lc; e.ovf = 1'b0; e.en = 1'b0; e.rstn = tbl[k].e_rstn;
            e.done = 1'b0;
            chk("table", 0, e);
        end

        do_reset_row("reset_after_table");
        idle_row("idle_after_table");

        // Budgeted run, then unbounded run halted in RUN cycle 37.
        do_run(20, -1, -1);
        do_run(0, 37, -1);

        // Five words: instance b overflows after three writes.
        q = '{32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003, 32'hC0DE_0004, 32'hC0DE_0005};
        do_load(q, 1'b0, 1'b0, -1);
        // A fresh image clears the overflow flag.
        q = '{32'h5A5A_0001};
        do_load(q, 1'b0, 1'b0, -1);

        // Reset in the middle of a load and of a run.
        q = '{32'h1, 32'h2, 32'h3, 32'h4};
        do_load(q, 1'b0, 1'b0, 2);
        do_run(10, -1, 8);
        do_run(3, -1, -1);

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(9, 0) < 5) begin
                n = $urandom_range(8, 1);
                q = {};
                for (int j = 0; j < n; j++) q.push_back($urandom);
                do_load(q, 1'($urandom_range(1, 0)), 1'b1,
                        ($urandom_range(9, 0) == 0) ? $urandom_range(n, 1) : -1);
            end else begin
                rc = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(30, 1);
                if (rc == 0) hk = $urandom_range(30, 0);
                else hk = ($urandom_range(2, 0) == 0) ? $urandom_range(rc - 1, 0) : -1;
                do_run(rc, hk, ($urandom_range(9, 0) == 0) ? $urandom_range(20, 1) : -1);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
